// File: rtl/hazard_fwd_ctrl.sv
// hazard_fwd_ctrl: scoreboard-based load-use stall, EX forwarding select, ID redirect flush and saturating counters
module hazard_fwd_ctrl #(
  parameter int REG_AW    = 5,
  parameter int FWD_DEPTH = 2,
  parameter int LOAD_LAT  = 1,
  parameter int CNT_W     = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              id_valid_i,
  input  logic [REG_AW-1:0] id_rs_i,
  input  logic [REG_AW-1:0] id_rt_i,
  input  logic              id_uses_rs_i,
  input  logic              id_uses_rt_i,
  input  logic [REG_AW-1:0] id_rd_i,
  input  logic              id_regwrite_i,
  input  logic              id_memread_i,
  input  logic              id_redirect_i,
  output logic              stall_o,
  output logic              idex_bubble_o,
  output logic              ifid_flush_o,
  output logic [2:0]        ex_fwd_rs_o,
  output logic [2:0]        ex_fwd_rt_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o
);
  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              regwrite;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic              uses_rs;
    logic              uses_rt;
    logic [2:0]        avail;
  } ent_t;

  ent_t sb_q [FWD_DEPTH+1];
  ent_t sb_d [FWD_DEPTH+1];
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  logic stall, flush, bad_fwd;
  logic [2:0] fwd_rs, fwd_rt;

  function automatic logic prod(input ent_t e, input logic [REG_AW-1:0] r);
    return e.valid & e.regwrite & (e.rd == r) & (e.rd != '0);
  endfunction

  // stall while any in-flight producer of a used ID source cannot yet forward
  always_comb begin
    stall = 1'b0;
    for (int k = 0; k < FWD_DEPTH; k++)
      if (((id_uses_rs_i && prod(sb_q[k], id_rs_i)) || (id_uses_rt_i && prod(sb_q[k], id_rt_i)))
          && int'(sb_q[k].avail) > k + 1)
        stall = 1'b1;
    stall = stall & id_valid_i;
    flush = rst_i & id_valid_i & id_redirect_i & ~stall;
  end

  // youngest ready producer wins: scan oldest to youngest so smaller k overwrites
  always_comb begin
    fwd_rs  = '0;
    fwd_rt  = '0;
    bad_fwd = 1'b0;
    for (int k = FWD_DEPTH; k >= 1; k--) begin
      if (sb_q[0].valid && sb_q[0].uses_rs && prod(sb_q[k], sb_q[0].rs)) begin
        if (int'(sb_q[k].avail) <= k) fwd_rs = 3'(k);
        else bad_fwd = 1'b1;
      end
      if (sb_q[0].valid && sb_q[0].uses_rt && prod(sb_q[k], sb_q[0].rt)) begin
        if (int'(sb_q[k].avail) <= k) fwd_rt = 3'(k);
        else bad_fwd = 1'b1;
      end
    end
  end

  // next scoreboard: shift towards retirement, insert ID or a bubble at EX
  always_comb begin
    sb_d[0] = '0;
    if (id_valid_i && !stall)
      sb_d[0] = ent_t'{valid: 1'b1, rd: id_rd_i, regwrite: id_regwrite_i, rs: id_rs_i, rt: id_rt_i,
                       uses_rs: id_uses_rs_i, uses_rt: id_uses_rt_i,
                       avail: id_memread_i ? 3'(1 + LOAD_LAT) : 3'd1};
    for (int k = 1; k <= FWD_DEPTH; k++) sb_d[k] = sb_q[k-1];
    stall_cnt_d = (stall && !(&stall_cnt_q)) ? stall_cnt_q + 1'b1 : stall_cnt_q;
    flush_cnt_d = (flush && !(&flush_cnt_q)) ? flush_cnt_q + 1'b1 : flush_cnt_q;
  end

  // state registers with asynchronous active-low clear
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int k = 0; k <= FWD_DEPTH; k++) sb_q[k] <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      for (int k = 0; k <= FWD_DEPTH; k++) sb_q[k] <= sb_d[k];
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // a matched producer that is not yet forwardable means the stall logic let a consumer through
  always @(posedge clk_i) if (rst_i) assert (!bad_fwd);

  assign stall_o       = stall;
  assign idex_bubble_o = stall;
  assign ifid_flush_o  = flush;
  assign ex_fwd_rs_o   = fwd_rs;
  assign ex_fwd_rt_o   = fwd_rt;
  assign stall_cnt_o   = stall_cnt_q;
  assign flush_cnt_o   = flush_cnt_q;
endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// tb_hazard_fwd_ctrl: directed pipeline scenarios with a queued expected-output scoreboard
module tb_hazard_fwd_ctrl;
  logic clk = 1'b0, rst_i = 1'b0;
  logic id_valid, id_urs, id_urt, id_rw, id_mr, id_rdr;
  logic [4:0] id_rs, id_rt, id_rd;
  logic st_a, bb_a, fl_a, st_b, bb_b, fl_b;
  logic [2:0] frs_a, frt_a, frs_b, frt_b;
  logic [15:0] sc_a, fc_a;
  logic [3:0] sc_b, fc_b;

  typedef struct {int inst, st, fl, frs, frt, sc, fc;} exp_t;
  exp_t exp_q[$];
  string nm_q[$];
  exp_t me;
  string mn;
  int checks = 0, failures = 0;
  event chk_ev;

  hazard_fwd_ctrl u_a (
    .clk_i(clk), .rst_i(rst_i), .id_valid_i(id_valid), .id_rs_i(id_rs), .id_rt_i(id_rt),
    .id_uses_rs_i(id_urs), .id_uses_rt_i(id_urt), .id_rd_i(id_rd), .id_regwrite_i(id_rw),
    .id_memread_i(id_mr), .id_redirect_i(id_rdr), .stall_o(st_a), .idex_bubble_o(bb_a),
    .ifid_flush_o(fl_a), .ex_fwd_rs_o(frs_a), .ex_fwd_rt_o(frt_a), .stall_cnt_o(sc_a),
    .flush_cnt_o(fc_a));

  hazard_fwd_ctrl #(.FWD_DEPTH(3), .LOAD_LAT(2), .CNT_W(4)) u_b (
    .clk_i(clk), .rst_i(rst_i), .id_valid_i(id_valid), .id_rs_i(id_rs), .id_rt_i(id_rt),
    .id_uses_rs_i(id_urs), .id_uses_rt_i(id_urt), .id_rd_i(id_rd), .id_regwrite_i(id_rw),
    .id_memread_i(id_mr), .id_redirect_i(id_rdr), .stall_o(st_b), .idex_bubble_o(bb_b),
    .ifid_flush_o(fl_b), .ex_fwd_rs_o(frs_b), .ex_fwd_rt_o(frt_b), .stall_cnt_o(sc_b),
    .flush_cnt_o(fc_b));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int req);
    if (req < 0) return;
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d required %0d", nm, act, req);
    end
  endtask

  task automatic cmp_all(input string n, input exp_t e, input int st, bb, fl, frs, frt, sc, fc);
    chk({n, ".stall"}, st, e.st);
    chk({n, ".bubble"}, bb, e.st);
    chk({n, ".flush"}, fl, e.fl);
    chk({n, ".fwd_rs"}, frs, e.frs);
    chk({n, ".fwd_rt"}, frt, e.frt);
    chk({n, ".stall_cnt"}, sc, e.sc);
    chk({n, ".flush_cnt"}, fc, e.fc);
  endtask

  // monitor: drain every expectation queued for the current cycle
  always begin
    @(negedge clk or chk_ev);
    while (exp_q.size() > 0) begin
      me = exp_q.pop_front();
      mn = nm_q.pop_front();
      if (me.inst == 0)
        cmp_all({mn, ".a"}, me, int'(st_a), int'(bb_a), int'(fl_a), int'(frs_a), int'(frt_a), int'(sc_a), int'(fc_a));
      else
        cmp_all({mn, ".b"}, me, int'(st_b), int'(bb_b), int'(fl_b), int'(frs_b), int'(frt_b), int'(sc_b), int'(fc_b));
    end
  end

  task automatic ex(input string nm, input int inst, st, fl, frs, frt, sc, fc);
    exp_t e;
    e = '{inst, st, fl, frs, frt, sc, fc};
    exp_q.push_back(e);
    nm_q.push_back(nm);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input int rs, rt, input logic urs, urt, input int rd,
                       input logic rw, mr, rdr);
    id_valid = v; id_rs = 5'(rs); id_rt = 5'(rt); id_urs = urs; id_urt = urt;
    id_rd = 5'(rd); id_rw = rw; id_mr = mr; id_rdr = rdr;
  endtask

  task automatic idle();             drive(0, 0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic ld(input int rd);   drive(1, 1, rd, 1, 0, rd, 1, 1, 0); endtask
  task automatic alu(input int rs, rt, rd); drive(1, rs, rt, 1, 1, rd, 1, 0, 0); endtask
  task automatic br(input int rs, rt); drive(1, rs, rt, 1, 1, 0, 0, 0, 1); endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    br(2, 3);
    tick();
    ex("reset", 0, 0, 0, 0, 0, 0, 0);
    ex("reset", 1, 0, 0, 0, 0, 0, 0);
    tick();
    rst_i = 1'b1;
    idle();
    tick();
    // load-use on default depth: one stall cycle then forward from stage 2
    ld(2);          ex("lu0", 0, 0, 0, 0, 0, 0, 0); tick();
    alu(2, 4, 3);   ex("lu1", 0, 1, 0, 0, 0, 0, 0); tick();
                    ex("lu2", 0, 0, 0, 0, 0, 1, 0); tick();
    idle();         ex("lu3", 0, 0, 0, 2, 0, 1, 0); tick();
                    ex("lu4", 0, 0, 0, 0, 0, 1, 0); tick();
    tick();
    // ALU chain: youngest producer forwards
    alu(1, 1, 5);   ex("ch0", 0, 0, 0, 0, 0, 1, 0); tick();
    alu(5, 5, 6);   ex("ch1", 0, 0, 0, 0, 0, 1, 0); tick();
    alu(5, 6, 7);   ex("ch2", 0, 0, 0, 1, 1, 1, 0); tick();
    idle();         ex("ch3", 0, 0, 0, 2, 1, 1, 0); tick();
                    ex("ch4", 0, 0, 0, 0, 0, 1, 0); tick();
    tick();
    // register zero is never a hazard or a source
    ld(0);          ex("z0", 0, 0, 0, 0, 0, 1, 0); tick();
    alu(0, 0, 9);   ex("z1", 0, 0, 0, 0, 0, 1, 0); tick();
    idle();         ex("z2", 0, 0, 0, 0, 0, 1, 0); tick();
    tick(); tick();
    // stalled branch defers its flush
    ld(2);          ex("br0", 0, 0, 0, 0, 0, 1, 0); tick();
    br(2, 3);       ex("br1", 0, 1, 0, 0, 0, 1, 0); tick();
                    ex("br2", 0, 0, 1, 0, 0, 2, 0); tick();
    idle();         ex("br3", 0, 0, 0, 2, 0, 2, 1); tick();
    tick(); tick();
    // asynchronous reset in the middle of a stall
    ld(2);          ex("ar0", 0, 0, 0, 0, 0, 2, 1); tick();
    alu(2, 4, 3);   ex("ar1", 0, 1, 0, 0, 0, 2, 1);
    @(negedge clk);
    #2;
    rst_i = 1'b0;
    #1;
    ex("ar_async", 0, 0, 0, 0, 0, 0, 0);
    ex("ar_async", 1, 0, 0, 0, 0, 0, 0);
    ->chk_ev;
    tick();
    rst_i = 1'b1;
    ex("ar_after", 0, 0, 0, 0, 0, 0, 0);
    ex("ar_after", 1, 0, 0, 0, 0, 0, 0);
    tick();
    idle();
    repeat (4) tick();
    // deep config: two-cycle load stall, forward from stage 3
    ld(8);          ex("dp0", 1, 0, 0, 0, 0, 0, 0); tick();
    alu(8, 4, 9);   ex("dp1", 1, 1, 0, 0, 0, 0, 0); tick();
                    ex("dp2", 1, 1, 0, 0, 0, 1, 0); tick();
                    ex("dp3", 1, 0, 0, 0, 0, 2, 0); tick();
    idle();         ex("dp4", 1, 0, 0, 3, 0, 2, 0); tick();
    repeat (3) tick();
    // 20 more stall cycles saturate the 4-bit counter
    for (int i = 0; i < 10; i++) begin
      ld(8);        ex("sat_ld", 1, 0, 0, -1, -1, -1, 0); tick();
      alu(8, 4, 9); ex("sat_s1", 1, 1, 0, -1, -1, -1, 0); tick();
                    ex("sat_s2", 1, 1, 0, -1, -1, -1, 0); tick();
                    ex("sat_go", 1, 0, 0, -1, -1, -1, 0); tick();
    end
    idle();         ex("sat_end", 1, 0, 0, -1, -1, 15, 0); tick();
    tick(); tick();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
